edge_det_multi: RTL
===================

EDGE_DET_MULTI -- requirements
Module: edge_det_multi

Interface
REQ-001 Parameter WIDTH, default 8, number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flops per channel (2..4).
REQ-003 Parameter FILT_CYCLES, default 4, consecutive mismatching samples needed to accept a level change (1..255); 1 = no filtering.
REQ-004 clk  input  1  sole clock; all flops rising-edge.
REQ-005 rstn  input  1  reset; asynchronous, active-low.
REQ-006 dat_i  input  WIDTH  asynchronous raw inputs, one per channel.
REQ-007 mode_i  input  2*WIDTH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-008 clr_i  input  WIDTH  write-1-to-clear for flag_o, one cycle per request.
REQ-009 dat_o  output  WIDTH  synchronised, filtered level per channel.
REQ-010 edge_rising  output  WIDTH  one-cycle pulse on filtered 0->1, regardless of mode.
REQ-011 edge_falling  output  WIDTH  one-cycle pulse on filtered 1->0, regardless of mode.
REQ-012 edge_pulse  output  WIDTH  one-cycle pulse on a mode-qualified edge.
REQ-013 flag_o  output  WIDTH  sticky mode-qualified edge flags.
REQ-014 irq_o  output  1  OR of all flag_o bits.

Function
REQ-015 Each channel SHALL pass dat_i through a SYNC_STAGES-deep flop chain; the last stage is the synced value.
REQ-016 Each channel SHALL hold a filter counter of ceil(log2(FILT_CYCLES+1)) bits (minimum 1) and a filtered level register driving dat_o.
REQ-017 Counter SHALL reset to 0 in any cycle where synced equals filtered level.
REQ-018 When synced differs from filtered level and counter equals FILT_CYCLES-1, the filtered level SHALL toggle and the counter SHALL return to 0 on that edge; otherwise the counter SHALL increment.
REQ-019 Counter SHALL never exceed FILT_CYCLES-1; no wrap-around.
REQ-020 Latency: a dat_i change first sampled at clock edge 0 and held stable SHALL appear on dat_o after edge SYNC_STAGES+FILT_CYCLES-1.
REQ-021 A synced pulse shorter than FILT_CYCLES cycles SHALL produce no dat_o change and no edge output.
REQ-022 edge_rising/edge_falling SHALL be registered and high for exactly the one cycle in which dat_o first shows the new level.
REQ-023 edge_pulse[i] SHALL equal (edge_rising[i] & mode bit0) | (edge_falling[i] & mode bit1), using mode_i sampled on the same edge the filtered level toggles; registered, same cycle as edge_rising/falling.
REQ-024 Mode change SHALL take effect for edges whose toggle edge follows the change; mode 00 SHALL NOT clear existing flags.
REQ-025 flag_o[i] SHALL set on the edge after edge_pulse[i] is high and clear on the edge after clr_i[i] is high.
REQ-026 Simultaneous set and clear on one channel SHALL leave the flag set (no lost event).
REQ-027 irq_o SHALL be combinational OR of flag_o; no other combinational input-to-output path.
REQ-028 Channels SHALL be fully independent; simultaneous edges on several channels SHALL all be reported in the same cycle.

Reset
REQ-029 While rstn low: sync chains, counters, dat_o, edge_rising, edge_falling, edge_pulse, flag_o SHALL be 0; irq_o SHALL be 0.
REQ-030 A channel whose dat_i is high at reset release SHALL report a rising edge after the REQ-020 latency.
REQ-031 Reset asserted mid-filter or mid-pulse SHALL abort immediately; no pulse or flag SHALL survive reset.

Verification (WIDTH=8, SYNC_STAGES=2, FILT_CYCLES=4)
REQ-032 dat_i[0] 0->1 held, mode 01 -> dat_o[0] high after edge 5; edge_rising[0], edge_pulse[0] high one cycle; flag_o[0], irq_o high one cycle later.
REQ-033 dat_i[3] high for 3 cycles then low -> dat_o, all edge outputs, flag_o stay 0.
REQ-034 Channel 2 mode 01, dat_i[2] falls after settling high -> edge_falling[2] pulses, edge_pulse[2] and flag_o[2] stay 0.
REQ-035 Flag set, then clr_i[1] asserted in the same cycle as a new edge_pulse[1] -> flag_o[1] remains 1; clr_i[1] alone next cycle -> flag_o[1]=0, irq_o=0.
REQ-036 dat_i=8'hFF at reset release, mode 11 all channels -> all 8 edge_rising bits pulse together after edge 5; rstn pulsed low mid-filter on a later change -> all outputs 0 immediately, no spurious pulse.

Source files
------------

// File: rtl/edge_det_multi.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter,
// registered rise/fall/mode-qualified pulses and sticky W1C flags.
module edge_det_multi #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [WIDTH-1:0]     dat_i,
    input  logic [2*WIDTH-1:0]   mode_i,
    input  logic [WIDTH-1:0]     clr_i,
    output logic [WIDTH-1:0]     dat_o,
    output logic [WIDTH-1:0]     edge_rising,
    output logic [WIDTH-1:0]     edge_falling,
    output logic [WIDTH-1:0]     edge_pulse,
    output logic [WIDTH-1:0]     flag_o,
    output logic                 irq_o
);

    localparam int unsigned CNT_W_RAW = $clog2(FILT_CYCLES + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]                  filt_q, filt_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;
    logic [WIDTH-1:0]                  pulse_q, pulse_d;
    logic [WIDTH-1:0]                  flag_q, flag_d;
    logic [WIDTH-1:0]                  synced_c;
    logic [WIDTH-1:0]                  toggle_c;

    // Synchroniser shift: new sample enters stage 0, last stage is the synced level.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], dat_i};
        synced_c = sync_q[SYNC_STAGES-1];
    end

    // Glitch filter: accept a new level only after FILT_CYCLES consecutive mismatches.
    always_comb begin
        cnt_d    = cnt_q;
        toggle_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (synced_c[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                cnt_d[i]    = '0;
                toggle_c[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        filt_d = filt_q ^ toggle_c;
    end

    // Edge pulses are computed on the toggle edge so they line up with the new dat_o level.
    always_comb begin
        rise_d  = toggle_c & ~filt_q;
        fall_d  = toggle_c & filt_q;
        pulse_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pulse_d[i] = (rise_d[i] & mode_i[2*i]) | (fall_d[i] & mode_i[2*i+1]);
        end
        // A pending pulse wins over a same-cycle clear so no event is lost.
        flag_d = (flag_q & ~clr_i) | pulse_q;
    end

    // All state registers; reset aborts any filtering or pulse in progress.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            filt_q  <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            pulse_q <= '0;
            flag_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
        end
    end

    assign dat_o        = filt_q;
    assign edge_rising  = rise_q;
    assign edge_falling = fall_q;
    assign edge_pulse   = pulse_q;
    assign flag_o       = flag_q;
    assign irq_o        = |flag_q;

endmodule
